// File: rtl/execute_flag_scheduler_if.sv
// rtl/execute_flag_scheduler_if.sv - issue, completion and flag-write bus of the flag scheduler
//
// Purpose: bundles the execute-stage signals seen by execute_flag_scheduler.
// Ports (slave = scheduler side):
//   iISSUE_VALID/iISSUE_FLAG_WRITE/iISSUE_UNIT  issue of a flag writer, unit tag
//   oISSUE_BUSY                                 order queue full
//   i<UNIT>_VALID/i<UNIT>_FLAG                  per-unit flag results (shift/adder/mul/logic)
//   oUNIT_STALL                                 per-unit latch full
//   oFLAG_WRITE_VALID/oFLAG_WRITE_DATA          registered flag register write
//   oFLAG_PENDING/oPENDING_COUNT                queue occupancy status
interface execute_flag_scheduler_if #(
  parameter int PTR_W = 2
);
  logic             iISSUE_VALID;
  logic             iISSUE_FLAG_WRITE;
  logic [1:0]       iISSUE_UNIT;
  logic             oISSUE_BUSY;
  logic             iSHIFT_VALID;
  logic             iADDER_VALID;
  logic             iMUL_VALID;
  logic             iLOGIC_VALID;
  logic [4:0]       iSHIFT_FLAG;
  logic [4:0]       iADDER_FLAG;
  logic [4:0]       iMUL_FLAG;
  logic [4:0]       iLOGIC_FLAG;
  logic [3:0]       oUNIT_STALL;
  logic             oFLAG_WRITE_VALID;
  logic [4:0]       oFLAG_WRITE_DATA;
  logic             oFLAG_PENDING;
  logic [PTR_W:0]   oPENDING_COUNT;

  modport slave (
    input  iISSUE_VALID, iISSUE_FLAG_WRITE, iISSUE_UNIT,
    input  iSHIFT_VALID, iADDER_VALID, iMUL_VALID, iLOGIC_VALID,
    input  iSHIFT_FLAG, iADDER_FLAG, iMUL_FLAG, iLOGIC_FLAG,
    output oISSUE_BUSY, oUNIT_STALL, oFLAG_WRITE_VALID, oFLAG_WRITE_DATA,
    output oFLAG_PENDING, oPENDING_COUNT
  );

  modport master (
    output iISSUE_VALID, iISSUE_FLAG_WRITE, iISSUE_UNIT,
    output iSHIFT_VALID, iADDER_VALID, iMUL_VALID, iLOGIC_VALID,
    output iSHIFT_FLAG, iADDER_FLAG, iMUL_FLAG, iLOGIC_FLAG,
    input  oISSUE_BUSY, oUNIT_STALL, oFLAG_WRITE_VALID, oFLAG_WRITE_DATA,
    input  oFLAG_PENDING, oPENDING_COUNT
  );
endinterface

// File: rtl/execute_flag_scheduler.sv
// rtl/execute_flag_scheduler.sv - in-order flag writeback scheduler for the execute stage
//
// Purpose: records the issue order of flag-writing instructions, buffers early
// unit results, and releases one flag update per cycle in program order.
// Ports:
//   iCLOCK       clock, rising edge
//   iRESET       asynchronous active-high reset
//   iRESET_SYNC  synchronous clear (same effect as iRESET)
//   iCTRL_HOLD   pipeline hold: no issue, no retire (latches still capture)
//   iFLUSH       synchronous clear of queue and latches, write data kept
//   bus          issue / completion / flag-write bus (slave side)
module execute_flag_scheduler #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                          iCLOCK,
  input  logic                          iRESET,
  input  logic                          iRESET_SYNC,
  input  logic                          iCTRL_HOLD,
  input  logic                          iFLUSH,
  execute_flag_scheduler_if.slave       bus
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [1:0]       tagQueue [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   countNext;
  logic [4:0]       latchData [4];
  logic [3:0]       latchFull;
  logic [3:0]       latchFullNext;
  logic [3:0]       captureUnit;
  logic             flagWriteValid;
  logic [4:0]       flagWriteData;

  logic [3:0]       unitValid;
  logic [4:0]       unitFlag [4];
  logic [1:0]       headTag;
  logic             issueBusy;
  logic             issueAccept;
  logic             canRetire;
  logic             retireFromLatch;
  logic             retireBypass;
  logic             retireNow;
  logic [4:0]       retireData;

  assign unitValid   = {bus.iLOGIC_VALID, bus.iMUL_VALID, bus.iADDER_VALID, bus.iSHIFT_VALID};
  assign unitFlag[0] = bus.iSHIFT_FLAG;
  assign unitFlag[1] = bus.iADDER_FLAG;
  assign unitFlag[2] = bus.iMUL_FLAG;
  assign unitFlag[3] = bus.iLOGIC_FLAG;

  // Busy looks only at the registered count, so a full queue blocks issue
  // even in a cycle where a retire frees an entry.
  assign issueBusy   = (count == FULL_COUNT);
  assign issueAccept = bus.iISSUE_VALID & bus.iISSUE_FLAG_WRITE & !issueBusy
                       & !iCTRL_HOLD & !iFLUSH;

  always_comb begin
    headTag         = tagQueue[headPtr];
    canRetire       = (count != '0) & !iCTRL_HOLD & !iFLUSH;
    // A buffered result is always older than a fresh completion of the same unit.
    retireFromLatch = canRetire & latchFull[headTag];
    retireBypass    = canRetire & !latchFull[headTag] & unitValid[headTag];
    retireNow       = retireFromLatch | retireBypass;
    retireData      = retireFromLatch ? latchData[headTag] : unitFlag[headTag];

    for (int u = 0; u < 4; u++) begin
      // Capture every completion except one consumed by the bypass path.
      captureUnit[u]   = unitValid[u] & !(retireBypass && (headTag == 2'(u)));
      latchFullNext[u] = latchFull[u];
      if (retireFromLatch && (headTag == 2'(u))) begin
        latchFullNext[u] = 1'b0;
      end
      if (captureUnit[u]) begin
        latchFullNext[u] = 1'b1;
      end
    end

    unique case ({issueAccept, retireNow})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Tag storage and latch payloads need no reset: validity lives in count/latchFull.
  always_ff @(posedge iCLOCK) begin
    if (issueAccept && !iRESET && !iRESET_SYNC) begin
      tagQueue[tailPtr] <= bus.iISSUE_UNIT;
    end
    for (int u = 0; u < 4; u++) begin
      if (captureUnit[u]) begin
        latchData[u] <= unitFlag[u];
      end
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      headPtr        <= '0;
      tailPtr        <= '0;
      count          <= '0;
      latchFull      <= '0;
      flagWriteValid <= 1'b0;
      flagWriteData  <= '0;
    end else if (iRESET_SYNC) begin
      headPtr        <= '0;
      tailPtr        <= '0;
      count          <= '0;
      latchFull      <= '0;
      flagWriteValid <= 1'b0;
      flagWriteData  <= '0;
    end else if (iFLUSH) begin
      headPtr        <= '0;
      tailPtr        <= '0;
      count          <= '0;
      latchFull      <= '0;
      flagWriteValid <= 1'b0;
    end else begin
      if (issueAccept) begin
        tailPtr <= tailPtr + 1'b1;
      end
      if (retireNow) begin
        headPtr       <= headPtr + 1'b1;
        flagWriteData <= retireData;
      end
      count          <= countNext;
      latchFull      <= latchFullNext;
      flagWriteValid <= retireNow;
    end
  end

  assign bus.oISSUE_BUSY       = issueBusy;
  assign bus.oUNIT_STALL       = latchFull;
  assign bus.oFLAG_WRITE_VALID = flagWriteValid;
  assign bus.oFLAG_WRITE_DATA  = flagWriteData;
  assign bus.oFLAG_PENDING     = (count != '0);
  assign bus.oPENDING_COUNT    = count;

endmodule

// File: tb/tb_execute_flag_scheduler.sv
// tb/tb_execute_flag_scheduler.sv - directed self-checking bench for execute_flag_scheduler
//
// Purpose: applies directed vectors with hand-computed expectations.
// Ports: none (top-level bench).
module tb_execute_flag_scheduler;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic iCLOCK = 1'b0;
  logic iRESET;
  logic iRESET_SYNC;
  logic iCTRL_HOLD;
  logic iFLUSH;

  int vectorCount = 0;
  int missCount   = 0;

  execute_flag_scheduler_if #(.PTR_W(PTR_W)) bus ();

  execute_flag_scheduler #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iCTRL_HOLD  (iCTRL_HOLD),
    .iFLUSH      (iFLUSH),
    .bus         (bus)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic idleInputs();
    bus.iISSUE_VALID      = 1'b0;
    bus.iISSUE_FLAG_WRITE = 1'b0;
    bus.iISSUE_UNIT       = 2'd0;
    bus.iSHIFT_VALID      = 1'b0;
    bus.iADDER_VALID      = 1'b0;
    bus.iMUL_VALID        = 1'b0;
    bus.iLOGIC_VALID      = 1'b0;
    bus.iSHIFT_FLAG       = 5'h00;
    bus.iADDER_FLAG       = 5'h00;
    bus.iMUL_FLAG         = 5'h00;
    bus.iLOGIC_FLAG       = 5'h00;
  endtask

  task automatic setIssue(input logic [1:0] unit);
    bus.iISSUE_VALID      = 1'b1;
    bus.iISSUE_FLAG_WRITE = 1'b1;
    bus.iISSUE_UNIT       = unit;
  endtask

  task automatic setUnit(input int unit, input logic [4:0] flag);
    case (unit)
      0: begin bus.iSHIFT_VALID = 1'b1; bus.iSHIFT_FLAG = flag; end
      1: begin bus.iADDER_VALID = 1'b1; bus.iADDER_FLAG = flag; end
      2: begin bus.iMUL_VALID   = 1'b1; bus.iMUL_FLAG   = flag; end
      default: begin bus.iLOGIC_VALID = 1'b1; bus.iLOGIC_FLAG = flag; end
    endcase
  endtask

  task automatic checkWrite(input string tag, input logic expValid, input logic [4:0] expData);
    checkValue({tag, "_valid"}, 8'(bus.oFLAG_WRITE_VALID), 8'(expValid));
    checkValue({tag, "_data"}, 8'(bus.oFLAG_WRITE_DATA), 8'(expData));
  endtask

  task automatic checkQueue(input string tag, input logic [2:0] expCount, input logic [3:0] expStall);
    checkValue({tag, "_count"}, 8'(bus.oPENDING_COUNT), 8'(expCount));
    checkValue({tag, "_pending"}, 8'(bus.oFLAG_PENDING), 8'(expCount != 3'd0));
    checkValue({tag, "_busy"}, 8'(bus.oISSUE_BUSY), 8'(expCount == 3'd4));
    checkValue({tag, "_stall"}, 8'(bus.oUNIT_STALL), 8'(expStall));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRESET      = 1'b1;
    iRESET_SYNC = 1'b0;
    iCTRL_HOLD  = 1'b0;
    iFLUSH      = 1'b0;
    idleInputs();
    step();
    step();
    checkWrite("reset", 1'b0, 5'h00);
    checkQueue("reset", 3'd0, 4'b0000);
    iRESET = 1'b0;
    step();

    // Adder issue, then completion while it is at head: bypass retire.
    setIssue(2'd1);
    step();
    idleInputs();
    checkQueue("add_issue", 3'd1, 4'b0000);
    setUnit(1, 5'h03);
    step();
    idleInputs();
    checkWrite("add_ret", 1'b1, 5'h03);
    checkQueue("add_ret", 3'd0, 4'b0000);
    step();
    checkWrite("add_idle", 1'b0, 5'h03);

    // Out-of-order: mul then logic; logic finishes first.
    setIssue(2'd2);
    step();
    setIssue(2'd3);
    step();
    idleInputs();
    checkQueue("ooo_issue", 3'd2, 4'b0000);
    setUnit(3, 5'h11);
    step();
    idleInputs();
    checkWrite("ooo_logic", 1'b0, 5'h03);
    checkQueue("ooo_logic", 3'd2, 4'b1000);
    step();
    step();
    setUnit(2, 5'h04);
    step();
    idleInputs();
    checkWrite("ooo_mul", 1'b1, 5'h04);
    checkQueue("ooo_mul", 3'd1, 4'b1000);
    step();
    checkWrite("ooo_latch", 1'b1, 5'h11);
    checkQueue("ooo_latch", 3'd0, 4'b0000);
    step();
    checkWrite("ooo_idle", 1'b0, 5'h11);

    // Fill with four shifts; a fifth issue must be refused.
    setIssue(2'd0);
    repeat (4) step();
    checkQueue("full", 3'd4, 4'b0000);
    step();
    idleInputs();
    checkQueue("full_5th", 3'd4, 4'b0000);
    setUnit(0, 5'h01);
    step();
    checkWrite("wrap_1", 1'b1, 5'h01);
    checkQueue("wrap_1", 3'd3, 4'b0000);
    setUnit(0, 5'h02);
    setIssue(2'd1);
    step();
    idleInputs();
    checkWrite("wrap_2", 1'b1, 5'h02);
    checkQueue("wrap_2_iss", 3'd3, 4'b0000);
    setUnit(1, 5'h0A);
    step();
    idleInputs();
    checkWrite("wrap_add_early", 1'b0, 5'h02);
    checkQueue("wrap_add_early", 3'd3, 4'b0010);
    setUnit(0, 5'h03);
    step();
    checkWrite("wrap_3", 1'b1, 5'h03);
    setUnit(0, 5'h04);
    step();
    idleInputs();
    checkWrite("wrap_4", 1'b1, 5'h04);
    checkQueue("wrap_4", 3'd1, 4'b0010);
    step();
    checkWrite("wrap_add", 1'b1, 5'h0A);
    checkQueue("wrap_add", 3'd0, 4'b0000);
    step();

    // Hold for three cycles while the adder completes.
    setIssue(2'd1);
    step();
    idleInputs();
    iCTRL_HOLD = 1'b1;
    setUnit(1, 5'h08);
    step();
    idleInputs();
    checkWrite("hold_cap", 1'b0, 5'h0A);
    checkQueue("hold_cap", 3'd1, 4'b0010);
    step();
    step();
    checkWrite("hold_3", 1'b0, 5'h0A);
    checkQueue("hold_3", 3'd1, 4'b0010);
    iCTRL_HOLD = 1'b0;
    step();
    checkWrite("hold_rel", 1'b1, 5'h08);
    checkQueue("hold_rel", 3'd0, 4'b0000);

    // Flush with three pending and a full mul latch.
    setIssue(2'd0);
    step();
    setIssue(2'd1);
    step();
    setIssue(2'd2);
    step();
    idleInputs();
    setUnit(2, 5'h1F);
    step();
    idleInputs();
    checkQueue("pre_flush", 3'd3, 4'b0100);
    iFLUSH = 1'b1;
    step();
    iFLUSH = 1'b0;
    checkWrite("flush", 1'b0, 5'h08);
    checkQueue("flush", 3'd0, 4'b0000);

    // Latch drain with a simultaneous new arrival from the same unit.
    setIssue(2'd0);
    step();
    setIssue(2'd2);
    step();
    idleInputs();
    setUnit(2, 5'h01);
    step();
    idleInputs();
    checkQueue("drain_cap", 3'd2, 4'b0100);
    setUnit(0, 5'h05);
    step();
    idleInputs();
    checkWrite("drain_shift", 1'b1, 5'h05);
    setUnit(2, 5'h02);
    step();
    idleInputs();
    checkWrite("drain_old", 1'b1, 5'h01);
    checkQueue("drain_old", 3'd0, 4'b0100);
    setIssue(2'd2);
    step();
    idleInputs();
    checkWrite("drain_issue", 1'b0, 5'h01);
    step();
    checkWrite("drain_new", 1'b1, 5'h02);
    checkQueue("drain_new", 3'd0, 4'b0000);

    // Synchronous reset also clears the write data.
    iRESET_SYNC = 1'b1;
    step();
    iRESET_SYNC = 1'b0;
    checkWrite("rst_sync", 1'b0, 5'h00);
    checkQueue("rst_sync", 3'd0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
